// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-fetch request channel between the PC sequencer and the I-cache.
interface pc_fetch_sequencer_if;
  logic        IReqValid;
  logic        IReqReady;
  logic [31:0] IReqAddr;

  // Sequencer side: issues requests, observes cache acceptance
  modport master (
    output IReqValid,
    output IReqAddr,
    input  IReqReady
  );

  // Cache side: receives requests, signals acceptance
  modport slave (
    input  IReqValid,
    input  IReqAddr,
    output IReqReady
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter and single-outstanding instruction-fetch sequencer.
// Redirects that arrive while a request waits on the cache are latched and
// applied when that request is accepted.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              PCTarget,
  input  logic                     PCSrc,
  input  logic                     Stall,
  pc_fetch_sequencer_if.master     ireq,
  output logic [31:0]              PC,
  output logic [31:0]              PCPlus4,
  output logic                     RedirectPending,
  output logic                     Misaligned,
  output logic [CNT_W-1:0]         FetchCount
);

  typedef enum logic [1:0] {StIdle, StFetch, StStall} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             pend_q, pend_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] tgt_aligned;
  logic        fire;

  assign tgt_aligned = {PCTarget[31:2], 2'b00};
  assign fire        = (state_q == StFetch) && ireq.IReqReady;

  // Next-state, next-PC, redirect latch and counter logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    cnt_d      = cnt_q;
    // Every PCSrc is a redirect, whether applied now or latched for later
    mis_d      = PCSrc && (PCTarget[1:0] != 2'b00);

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (PCSrc) begin
          pc_d   = tgt_aligned;
          pend_d = 1'b0;
        end
      end
      StFetch: begin
        if (fire) begin
          if (PCSrc) begin
            pc_d = tgt_aligned;
          end else if (pend_q) begin
            pc_d = pend_tgt_q;
          end else begin
            pc_d = pc_q + 32'd4;
          end
          pend_d  = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = Stall ? StStall : StFetch;
        end else if (PCSrc) begin
          // Request must stay stable; newest target wins
          pend_d     = 1'b1;
          pend_tgt_d = tgt_aligned;
        end
      end
      StStall: begin
        if (PCSrc) begin
          pc_d   = tgt_aligned;
          pend_d = 1'b0;
        end
        if (!Stall) begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'h0000_0000;
      mis_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ireq.IReqValid = (state_q == StFetch);
  assign ireq.IReqAddr  = pc_q;
  assign PC             = pc_q;
  assign PCPlus4        = pc_q + 32'd4;
  assign RedirectPending = pend_q;
  assign Misaligned     = mis_q;
  assign FetchCount     = cnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: inputs change 1 ns after a rising
// edge and outputs are checked there, well away from the next edge.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCTarget;
  logic        PCSrc;
  logic        Stall;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        RedirectPending;
  logic        Misaligned;
  logic [15:0] FetchCount;

  int checks;
  int failures;

  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PCTarget        (PCTarget),
    .PCSrc           (PCSrc),
    .Stall           (Stall),
    .ireq            (bus.master),
    .PC              (PC),
    .PCPlus4         (PCPlus4),
    .RedirectPending (RedirectPending),
    .Misaligned      (Misaligned),
    .FetchCount      (FetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    PCTarget = 32'h0;
    PCSrc    = 1'b0;
    Stall    = 1'b0;
    bus.IReqReady = 1'b0;

    // Reset values
    #3;
    chk("rst_pc", PC, 32'h0);
    chk("rst_addr", bus.IReqAddr, 32'h0);
    chk("rst_pcplus4", PCPlus4, 32'h4);
    chk("rst_valid", {31'h0, bus.IReqValid}, 32'h0);
    chk("rst_pend", {31'h0, RedirectPending}, 32'h0);
    chk("rst_mis", {31'h0, Misaligned}, 32'h0);
    chk("rst_cnt", {16'h0, FetchCount}, 32'h0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("first_valid", {31'h0, bus.IReqValid}, 32'h1);
    chk("first_addr", bus.IReqAddr, 32'h0);

    // Back-to-back fetches
    bus.IReqReady = 1'b1;
    tick(); chk("seq_4", bus.IReqAddr, 32'h4);
    tick(); chk("seq_8", bus.IReqAddr, 32'h8);
    tick(); chk("seq_c", bus.IReqAddr, 32'hC);
    tick(); chk("seq_10", bus.IReqAddr, 32'h10);
    chk("cnt_4", {16'h0, FetchCount}, 32'd4);

    // Redirect latched during an unaccepted request
    bus.IReqReady = 1'b0;
    tick(); chk("hold1_addr", bus.IReqAddr, 32'h10);
    PCSrc = 1'b1; PCTarget = 32'h200;
    tick(); chk("hold2_addr", bus.IReqAddr, 32'h10);
    chk("hold2_pend", {31'h0, RedirectPending}, 32'h1);
    chk("hold2_valid", {31'h0, bus.IReqValid}, 32'h1);
    PCSrc = 1'b0;
    tick(); chk("hold3_addr", bus.IReqAddr, 32'h10);
    chk("hold3_pend", {31'h0, RedirectPending}, 32'h1);
    bus.IReqReady = 1'b1;
    tick(); chk("redir_addr", bus.IReqAddr, 32'h200);
    chk("redir_pend", {31'h0, RedirectPending}, 32'h0);
    chk("cnt_5", {16'h0, FetchCount}, 32'd5);

    // Newest latched target wins
    bus.IReqReady = 1'b0;
    PCSrc = 1'b1; PCTarget = 32'h300;
    tick();
    PCTarget = 32'h400;
    tick();
    PCSrc = 1'b0;
    tick(); chk("two_hold_addr", bus.IReqAddr, 32'h200);
    bus.IReqReady = 1'b1;
    tick(); chk("two_newest", bus.IReqAddr, 32'h400);

    // Same-cycle PCSrc beats a pending target
    bus.IReqReady = 1'b0;
    PCSrc = 1'b1; PCTarget = 32'h400;
    tick(); chk("pend_again", {31'h0, RedirectPending}, 32'h1);
    bus.IReqReady = 1'b1;
    PCTarget = 32'h500;
    tick(); chk("direct_wins", bus.IReqAddr, 32'h500);
    chk("direct_pend", {31'h0, RedirectPending}, 32'h0);
    chk("cnt_7", {16'h0, FetchCount}, 32'd7);

    // Stall at fire, redirect while stalled
    PCTarget = 32'h20;
    tick(); chk("to_20", bus.IReqAddr, 32'h20);
    PCSrc = 1'b0; Stall = 1'b1;
    tick(); chk("stall_valid", {31'h0, bus.IReqValid}, 32'h0);
    chk("stall_pc", PC, 32'h24);
    PCSrc = 1'b1; PCTarget = 32'h80;
    tick(); chk("stall_redir_pc", PC, 32'h80);
    chk("stall_redir_valid", {31'h0, bus.IReqValid}, 32'h0);
    chk("stall_redir_pend", {31'h0, RedirectPending}, 32'h0);
    PCSrc = 1'b0; Stall = 1'b0;
    tick(); chk("unstall_valid", {31'h0, bus.IReqValid}, 32'h1);
    chk("unstall_addr", bus.IReqAddr, 32'h80);
    // Stall without a fire has no effect
    bus.IReqReady = 1'b0; Stall = 1'b1;
    tick(); chk("stall_nofire_valid", {31'h0, bus.IReqValid}, 32'h1);
    chk("stall_nofire_addr", bus.IReqAddr, 32'h80);
    Stall = 1'b0;
    chk("cnt_9", {16'h0, FetchCount}, 32'd9);

    // Misaligned direct redirect
    bus.IReqReady = 1'b1;
    PCSrc = 1'b1; PCTarget = 32'h0000_1236;
    tick(); chk("mis_addr", bus.IReqAddr, 32'h1234);
    chk("mis_pulse", {31'h0, Misaligned}, 32'h1);
    PCSrc = 1'b0;
    tick(); chk("mis_clear", {31'h0, Misaligned}, 32'h0);
    chk("mis_next", bus.IReqAddr, 32'h1238);

    // Misaligned latched redirect
    bus.IReqReady = 1'b0;
    PCSrc = 1'b1; PCTarget = 32'h2003;
    tick(); chk("lmis_pulse", {31'h0, Misaligned}, 32'h1);
    chk("lmis_hold", bus.IReqAddr, 32'h1238);
    PCSrc = 1'b0;
    tick(); chk("lmis_clear", {31'h0, Misaligned}, 32'h0);
    bus.IReqReady = 1'b1;
    tick(); chk("lmis_addr", bus.IReqAddr, 32'h2000);
    chk("lmis_nopulse", {31'h0, Misaligned}, 32'h0);

    // PC wrap
    PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFC;
    tick(); chk("wrap_top", bus.IReqAddr, 32'hFFFF_FFFC);
    chk("wrap_plus4", PCPlus4, 32'h0);
    PCSrc = 1'b0;
    tick(); chk("wrap_zero", bus.IReqAddr, 32'h0);
    chk("cnt_14", {16'h0, FetchCount}, 32'd14);

    // Reset mid-request with a pending redirect
    PCSrc = 1'b1; PCTarget = 32'h40;
    tick(); chk("pre_rst_addr", bus.IReqAddr, 32'h40);
    bus.IReqReady = 1'b0;
    PCTarget = 32'h60;
    tick(); chk("pre_rst_pend", {31'h0, RedirectPending}, 32'h1);
    PCSrc = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", bus.IReqAddr, 32'h0);
    chk("mid_rst_valid", {31'h0, bus.IReqValid}, 32'h0);
    chk("mid_rst_pend", {31'h0, RedirectPending}, 32'h0);
    chk("mid_rst_cnt", {16'h0, FetchCount}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(); chk("post_rst_valid", {31'h0, bus.IReqValid}, 32'h1);
    chk("post_rst_addr", bus.IReqAddr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
